serial_subtractor: RTL

- Bit-serial N-bit unsigned subtractor built around one full_subtractor cell plus a registered borrow.
- Loads two operands on a start handshake and processes one bit per clock, LSB first.
- Presents the WIDTH-bit difference and the final borrow-out with a one-cycle done pulse.
- Sits directly downstream of the full_subtractor cell: the first sequential datapath that consumes its diff/bout outputs.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_full_subtractor.sv | 22 ++
 rtl/serial_subtractor.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Purpose : shared constants for the bit-serial subtractor slice.
//           - FSM state encoding (2 bits; the unused code 3 behaves as IDLE)
//           - default operand width
// Ports   : none (package)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Purpose : single-bit subtract cell, computes a - b - bin.
// Ports   : a    in  minuend bit
//           b    in  subtrahend bit
//           bin  in  borrow in
//           diff out difference bit
//           bout out borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   // Borrow when b exceeds a, or when they are equal and a borrow comes in.
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Purpose : bit-serial unsigned subtractor, LSB first, one bit per clock.
//           Operands are captured on an accepted start; the difference and
//           final borrow are registered and flagged by a one-cycle done pulse.
// Ports   : clk   in  rising-edge clock
//           rst   in  synchronous active-high reset
//           start in  request, sampled only while idle
//           a     in  WIDTH minuend
//           b     in  WIDTH subtrahend
//           busy  out high while shifting and during the done cycle
//           done  out one-cycle result-valid pulse
//           diff  out WIDTH (a - b) mod 2^WIDTH
//           bout  out final borrow, 1 iff a < b
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e           r_state;
   logic [WIDTH-1:0] r_areg;
   logic [WIDTH-1:0] r_breg;
   logic [WIDTH-1:0] r_res;
   logic             r_borrow;
   logic [CNT_W-1:0] r_cnt;

   logic             w_d;
   logic             w_bo;
   logic [WIDTH-1:0] w_res_next;

   full_subtractor u_cell (
      .a    (r_areg[0]),
      .b    (r_breg[0]),
      .bin  (r_borrow),
      .diff (w_d),
      .bout (w_bo)
   );

   // New difference bit enters at the MSB so that after WIDTH shifts the
   // first (LSB) result bit has arrived at bit 0.
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_areg   <= '0;
         r_breg   <= '0;
         r_res    <= '0;
         r_borrow <= 1'b0;
         r_cnt    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         diff     <= '0;
         bout     <= 1'b0;
      end else begin
         case (r_state)
            ST_SHIFT: begin
               r_areg   <= r_areg >> 1;
               r_breg   <= r_breg >> 1;
               r_res    <= w_res_next;
               r_borrow <= w_bo;
               r_cnt    <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_BIT) begin
                  diff    <= w_res_next;
                  bout    <= w_bo;
                  done    <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               // IDLE, and the unused encoding which behaves identically.
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  r_areg   <= a;
                  r_breg   <= b;
                  r_res    <= '0;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
                  busy     <= 1'b1;
                  r_state  <= ST_SHIFT;
               end else begin
                  r_state  <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule
